// File: rtl/pi_loop_filter.sv
// PI loop filter for the ADPLL: turns the signed error word into the DCO tuning word.
// Ports: clk_ref, n_rst, enable, clear, lf_in -> dco_ctrl, locked, mode, sat.
module pi_loop_filter #(
   parameter int ERR_SIZE      = 8,
   parameter int CTRL_SIZE     = 10,
   parameter int ACC_SIZE      = 16,
   parameter int KP_ACQ_SHIFT  = 1,
   parameter int KI_ACQ_SHIFT  = 3,
   parameter int KP_TRK_SHIFT  = 3,
   parameter int KI_TRK_SHIFT  = 6,
   parameter int LOCK_THRESH   = 4,
   parameter int LOCK_CYCLES   = 8,
   parameter int UNLOCK_THRESH = 64
) (
   input  logic                 clk_ref,
   input  logic                 n_rst,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [ERR_SIZE-1:0]  lf_in,
   output logic [CTRL_SIZE-1:0] dco_ctrl,
   output logic                 locked,
   output logic [1:0]           mode,
   output logic                 sat
);

   localparam int FRAC = ACC_SIZE - CTRL_SIZE;
   localparam int W    = ACC_SIZE + 2;
   localparam int CW   = $clog2(LOCK_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACQ  = 2'd1;
   localparam logic [1:0] S_TRK  = 2'd2;

   localparam logic signed [W-1:0] I_MAX = W'(2 ** (ACC_SIZE - 1) - 1);
   localparam logic signed [W-1:0] I_MIN = W'(-(2 ** (ACC_SIZE - 1)));
   localparam logic signed [W-1:0] O_MAX = W'(2 ** CTRL_SIZE - 1);
   localparam logic signed [W-1:0] MID_W = W'(2 ** (CTRL_SIZE - 1));
   localparam logic signed [W-1:0] ZERO  = '0;

   localparam logic [CTRL_SIZE-1:0] MID = CTRL_SIZE'(2 ** (CTRL_SIZE - 1));
   localparam logic [ERR_SIZE:0]    LK_TH = (ERR_SIZE + 1)'(LOCK_THRESH);
   localparam logic [ERR_SIZE:0]    UL_TH = (ERR_SIZE + 1)'(UNLOCK_THRESH);
   localparam logic [CW-1:0]        LK_N  = CW'(LOCK_CYCLES);

   logic signed [ACC_SIZE-1:0] integ;
   logic [CW-1:0]              lock_cnt;

   logic signed [W-1:0]   e;
   logic signed [W-1:0]   ki;
   logic signed [W-1:0]   kp;
   logic signed [W-1:0]   sum_i;
   logic signed [W-1:0]   integ_c;
   logic signed [W-1:0]   raw;
   logic [CTRL_SIZE-1:0]  dco_n;
   logic                  i_clamp;
   logic                  o_clamp;
   logic                  hold_i;
   logic                  trk;
   logic [ERR_SIZE:0]     lf_ext;
   logic [ERR_SIZE:0]     mag;
   logic [CW-1:0]         cnt_inc;

   // IDLE uses the acquisition gains so the very first sample is filtered.
   assign trk = (mode == S_TRK);

   always_comb begin
      e = signed'({{(W-ERR_SIZE){lf_in[ERR_SIZE-1]}}, lf_in}) <<< FRAC;
      ki = trk ? (e >>> KI_TRK_SHIFT) : (e >>> KI_ACQ_SHIFT);
      kp = trk ? (e >>> KP_TRK_SHIFT) : (e >>> KP_ACQ_SHIFT);
      sum_i = signed'({{2{integ[ACC_SIZE-1]}}, integ}) + ki;
      i_clamp = 1'b1;
      if (sum_i > I_MAX)
         integ_c = I_MAX;
      else if (sum_i < I_MIN)
         integ_c = I_MIN;
      else begin
         integ_c = sum_i;
         i_clamp = 1'b0;
      end
      raw = ((integ_c + kp) >>> FRAC) + MID_W;
      o_clamp = 1'b1;
      if (raw > O_MAX)
         dco_n = O_MAX[CTRL_SIZE-1:0];
      else if (raw < ZERO)
         dco_n = '0;
      else begin
         dco_n = raw[CTRL_SIZE-1:0];
         o_clamp = 1'b0;
      end
      // Anti-windup: do not push further into an already clamped output.
      hold_i = ((raw > O_MAX) && (ki > ZERO))
            || ((raw < ZERO) && (ki < ZERO));
   end

   // 9-bit magnitude so that -128 maps to +128.
   assign lf_ext  = {lf_in[ERR_SIZE-1], lf_in};
   assign mag     = lf_in[ERR_SIZE-1] ? (~lf_ext + 1'b1) : lf_ext;
   assign cnt_inc = lock_cnt + 1'b1;

   always_ff @(posedge clk_ref or negedge n_rst) begin
      if (!n_rst) begin
         integ    <= '0;
         dco_ctrl <= MID;
         locked   <= 1'b0;
         mode     <= S_IDLE;
         sat      <= 1'b0;
         lock_cnt <= '0;
      end else if (clear) begin
         integ    <= '0;
         dco_ctrl <= MID;
         locked   <= 1'b0;
         mode     <= S_ACQ;
         sat      <= 1'b0;
         lock_cnt <= '0;
      end else if (enable) begin
         if (!hold_i)
            integ <= integ_c[ACC_SIZE-1:0];
         dco_ctrl <= dco_n;
         sat      <= i_clamp | o_clamp;
         case (mode)
            S_IDLE: begin
               mode <= S_ACQ;
            end
            S_ACQ: begin
               if (mag <= LK_TH) begin
                  if (cnt_inc == LK_N) begin
                     mode     <= S_TRK;
                     locked   <= 1'b1;
                     lock_cnt <= '0;
                  end else begin
                     lock_cnt <= cnt_inc;
                  end
               end else begin
                  lock_cnt <= '0;
               end
            end
            S_TRK: begin
               if (mag > UL_TH) begin
                  mode   <= S_ACQ;
                  locked <= 1'b0;
               end
            end
            default: begin
               mode   <= S_IDLE;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule
